// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline stage registers: IF/ID payload layout, RISC-V NOP,
// and the per-cycle transfer decode used by pipe_stage_reg.
package pipe_stage_reg_pkg;

    localparam logic [31:0] RV_NOP    = 32'h0000_0013;
    localparam int          PC_W      = 32;
    localparam int          INSTR_W   = 32;
    localparam int          IFID_W    = PC_W + INSTR_W;
    localparam int          INSTR_LSB = 0;
    localparam int          PC_LSB    = INSTR_W;

    // An empty IF/ID slot presents pc=0 and a canonical NOP instruction.
    localparam logic [IFID_W-1:0] IFID_NOP = {32'h0, RV_NOP};

    typedef enum logic [2:0] {
        XFER_HOLD,
        XFER_LOAD,
        XFER_SKID,
        XFER_POP,
        XFER_DRAIN
    } xfer_e;

    function automatic logic [IFID_W-1:0] ifid_pack(input logic [PC_W-1:0]    pc,
                                                    input logic [INSTR_W-1:0] instr);
        return {pc, instr};
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Handshake bundle between two pipeline stages plus the stage's control/status pins.
interface pipe_stage_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              stall;
    logic              flush;
    logic [CNT_W-1:0]  kill_cnt;

    modport master (
        output in_valid, in_data, out_ready, stall, flush,
        input  in_ready, out_valid, out_data, kill_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, stall, flush,
        output in_ready, out_valid, out_data, kill_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush-to-NOP,
// optional skid slot and a saturating count of entries killed by flush.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter bit                SKID_EN = 1'b1,
    parameter int                CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_stage_if.slave   bus
);

    logic              m_v;
    logic [DATA_W-1:0] m_d;
    logic              s_v;
    logic [DATA_W-1:0] s_d;
    logic [CNT_W-1:0]  kill_cnt;

    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    xfer_e             xfer;
    logic [CNT_W:0]    kill_sum;
    logic [CNT_W-1:0]  kill_next;

    assign out_fire = m_v & bus.out_ready & ~bus.stall;
    assign in_fire  = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = m_v;
    assign bus.out_data  = m_d;
    assign bus.kill_cnt  = kill_cnt;

    always_comb begin
        xfer = XFER_HOLD;
        if (in_fire && (!m_v || out_fire))
            xfer = XFER_LOAD;
        else if (in_fire)
            xfer = XFER_SKID;
        else if (out_fire && s_v)
            xfer = XFER_POP;
        else if (out_fire)
            xfer = XFER_DRAIN;
    end

    // One extra bit catches overflow of count + up to two kills; clamp instead of wrapping.
    assign kill_sum  = {1'b0, kill_cnt} + {{CNT_W{1'b0}}, m_v} + {{CNT_W{1'b0}}, s_v};
    assign kill_next = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v      <= 1'b0;
            m_d      <= NOP_VAL;
            kill_cnt <= '0;
        end else if (bus.flush) begin
            m_v      <= 1'b0;
            m_d      <= NOP_VAL;
            kill_cnt <= kill_next;
        end else begin
            case (xfer)
                XFER_LOAD: begin
                    m_v <= 1'b1;
                    m_d <= bus.in_data;
                end
                XFER_POP:  m_d <= s_d;
                XFER_DRAIN: begin
                    m_v <= 1'b0;
                    m_d <= NOP_VAL;
                end
                default: ;
            endcase
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            // Ready depends only on skid occupancy, so no comb path from downstream.
            assign in_ready = ~s_v;

            always_ff @(posedge clk) begin
                if (rst || bus.flush) begin
                    s_v <= 1'b0;
                    s_d <= NOP_VAL;
                end else begin
                    case (xfer)
                        XFER_SKID: begin
                            s_v <= 1'b1;
                            s_d <= bus.in_data;
                        end
                        XFER_POP: begin
                            s_v <= 1'b0;
                            s_d <= NOP_VAL;
                        end
                        default: ;
                    endcase
                end
            end
        end else begin : g_no_skid
            assign in_ready = ~m_v | out_fire;
            assign s_v      = 1'b0;
            assign s_d      = NOP_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations run in lockstep against a FIFO-occupancy model.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        t_valid [NDUT];
    logic [63:0] t_data  [NDUT];
    logic        t_ordy  [NDUT];
    logic        t_stall [NDUT];
    logic        t_flush [NDUT];

    logic        o_irdy   [NDUT];
    logic        o_ovalid [NDUT];
    logic [63:0] o_odata  [NDUT];
    logic [31:0] o_kill   [NDUT];

    pipe_stage_if #(.DATA_W(IFID_W), .CNT_W(16)) bus0 ();
    pipe_stage_if #(.DATA_W(16),     .CNT_W(8))  bus1 ();
    pipe_stage_if #(.DATA_W(8),      .CNT_W(2))  bus2 ();

    assign bus0.in_valid = t_valid[0];
    assign bus0.in_data  = t_data[0];
    assign bus0.out_ready = t_ordy[0];
    assign bus0.stall    = t_stall[0];
    assign bus0.flush    = t_flush[0];
    assign o_irdy[0]     = bus0.in_ready;
    assign o_ovalid[0]   = bus0.out_valid;
    assign o_odata[0]    = bus0.out_data;
    assign o_kill[0]     = {16'h0, bus0.kill_cnt};

    assign bus1.in_valid = t_valid[1];
    assign bus1.in_data  = t_data[1][15:0];
    assign bus1.out_ready = t_ordy[1];
    assign bus1.stall    = t_stall[1];
    assign bus1.flush    = t_flush[1];
    assign o_irdy[1]     = bus1.in_ready;
    assign o_ovalid[1]   = bus1.out_valid;
    assign o_odata[1]    = {48'h0, bus1.out_data};
    assign o_kill[1]     = {24'h0, bus1.kill_cnt};

    assign bus2.in_valid = t_valid[2];
    assign bus2.in_data  = t_data[2][7:0];
    assign bus2.out_ready = t_ordy[2];
    assign bus2.stall    = t_stall[2];
    assign bus2.flush    = t_flush[2];
    assign o_irdy[2]     = bus2.in_ready;
    assign o_ovalid[2]   = bus2.out_valid;
    assign o_odata[2]    = {56'h0, bus2.out_data};
    assign o_kill[2]     = {30'h0, bus2.kill_cnt};

    pipe_stage_reg #(.DATA_W(IFID_W), .NOP_VAL(IFID_NOP), .SKID_EN(1'b1), .CNT_W(16))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipe_stage_reg #(.DATA_W(16), .NOP_VAL(16'h00A5), .SKID_EN(1'b0), .CNT_W(8))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipe_stage_reg #(.DATA_W(8), .NOP_VAL(8'h00), .SKID_EN(1'b1), .CNT_W(2))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic logic [63:0] nop_of(input int d);
        case (d)
            0:       return IFID_NOP;
            1:       return 64'h00A5;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int d);
        case (d)
            0:       return {64{1'b1}};
            1:       return 64'hFFFF;
            default: return 64'hFF;
        endcase
    endfunction

    function automatic int cap_of(input int d);
        return (d == 1) ? 1 : 2;
    endfunction

    function automatic int cmax_of(input int d);
        case (d)
            0:       return 65535;
            1:       return 255;
            default: return 3;
        endcase
    endfunction

    // Model: each stage is a FIFO of held payloads plus a kill tally.
    logic [63:0] mq [NDUT][2];
    int          mn [NDUT];
    int          mk [NDUT];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) begin
            t_valid[d] = 1'b0;
            t_data[d]  = 64'h0;
            t_ordy[d]  = 1'b0;
            t_stall[d] = 1'b0;
            t_flush[d] = 1'b0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            logic        ev;
            logic [63:0] ed;
            logic        ofire;
            logic        er;
            logic        ifire;
            int          tot;
            ev    = mn[d] > 0;
            ed    = ev ? mq[d][0] : nop_of(d);
            ofire = ev && t_ordy[d] && !t_stall[d];
            er    = (cap_of(d) == 2) ? (mn[d] < 2) : (mn[d] == 0 || ofire);
            ifire = t_valid[d] && er;
            if (!rst) begin
                chk($sformatf("d%0d in_ready", d),  {63'h0, o_irdy[d]},   {63'h0, er});
                chk($sformatf("d%0d out_valid", d), {63'h0, o_ovalid[d]}, {63'h0, ev});
                chk($sformatf("d%0d out_data", d),  o_odata[d],           ed);
                chk($sformatf("d%0d kill_cnt", d),  {32'h0, o_kill[d]},   64'(mk[d]));
            end
            if (rst) begin
                mn[d] = 0;
                mk[d] = 0;
            end else if (t_flush[d]) begin
                tot   = mk[d] + mn[d];
                mk[d] = (tot > cmax_of(d)) ? cmax_of(d) : tot;
                mn[d] = 0;
            end else begin
                if (ofire) begin
                    mq[d][0] = mq[d][1];
                    mn[d]--;
                end
                if (ifire) begin
                    mq[d][mn[d]] = t_data[d] & mask_of(d);
                    mn[d]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            mn[d] = 0;
            mk[d] = 0;
            mq[d][0] = 64'h0;
            mq[d][1] = 64'h0;
        end
        idle_all();
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) t_valid[d] = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        idle_all();
        #1;
        chk("rst out_valid", {63'h0, o_ovalid[0]}, 64'h0);
        chk("rst out_data",  o_odata[0], IFID_NOP);
        chk("rst in_ready",  {63'h0, o_irdy[0]}, 64'h1);
        chk("rst kill_cnt",  {32'h0, o_kill[0]}, 64'h0);
        chk("rst nop d1",    o_odata[1], 64'h00A5);

        // Back-to-back stream: each payload visible exactly one cycle after it is offered.
        for (int i = 1; i <= 8; i++) begin
            t_valid[0] = 1'b1;
            t_data[0]  = 64'(i);
            t_ordy[0]  = 1'b1;
            cyc();
            chk($sformatf("stream out %0d", i), o_odata[0], 64'(i));
        end
        t_valid[0] = 1'b0;
        cyc();
        cyc();

        // Stall with skid: A held at output, B parked, C refused until space frees up.
        t_ordy[0] = 1'b1;
        t_valid[0] = 1'b1; t_data[0] = 64'hA;
        cyc();
        t_data[0] = 64'hB; t_stall[0] = 1'b1;
        cyc();
        t_data[0] = 64'hC;
        chk("stall out A",    o_odata[0], 64'hA);
        chk("stall in_ready", {63'h0, o_irdy[0]}, 64'h0);
        cyc();
        chk("stall hold A", o_odata[0], 64'hA);
        t_stall[0] = 1'b0;
        cyc();
        chk("release out B", o_odata[0], 64'hB);
        cyc();
        chk("release out C", o_odata[0], 64'hC);
        t_valid[0] = 1'b0;
        cyc();

        // Flush with both slots full and a new payload offered.
        t_ordy[0] = 1'b0;
        t_valid[0] = 1'b1; t_data[0] = 64'hA1;
        cyc();
        t_data[0] = 64'hB2;
        cyc();
        t_flush[0] = 1'b1; t_data[0] = 64'hD4;
        cyc();
        t_flush[0] = 1'b0; t_valid[0] = 1'b0;
        chk("flush out_valid", {63'h0, o_ovalid[0]}, 64'h0);
        chk("flush out_data",  o_odata[0], IFID_NOP);
        chk("flush kill +2",   {32'h0, o_kill[0]}, 64'h2);
        t_ordy[0] = 1'b1;
        cyc();
        cyc();
        chk("flush D dropped", {63'h0, o_ovalid[0]}, 64'h0);

        // Two-bit kill counter must stick at 3.
        for (int r = 0; r < 3; r++) begin
            t_ordy[2] = 1'b0;
            t_valid[2] = 1'b1; t_data[2] = 64'(8'h10 + r);
            cyc();
            t_data[2] = 64'(8'h20 + r);
            cyc();
            t_valid[2] = 1'b0; t_flush[2] = 1'b1;
            cyc();
            t_flush[2] = 1'b0;
            chk($sformatf("sat kill r%0d", r), {32'h0, o_kill[2]}, (r == 0) ? 64'h2 : 64'h3);
        end
        cyc();
        chk("sat kill hold", {32'h0, o_kill[2]}, 64'h3);

        // No-skid configuration: ready follows downstream combinationally.
        t_ordy[1] = 1'b0;
        t_valid[1] = 1'b1; t_data[1] = 64'h1A1A;
        cyc();
        t_valid[1] = 1'b0;
        #1;
        chk("noskid blocked", {63'h0, o_irdy[1]}, 64'h0);
        t_valid[1] = 1'b1; t_data[1] = 64'h0B0B; t_ordy[1] = 1'b1;
        #1;
        chk("noskid pass", {63'h0, o_irdy[1]}, 64'h1);
        cyc();
        t_valid[1] = 1'b0;
        chk("noskid out B", o_odata[1], 64'h0B0B);
        cyc();

        // Random traffic on all three stages at once.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                t_valid[d] = $urandom_range(0, 9) < 7;
                t_data[d]  = ifid_pack($urandom, $urandom);
                t_ordy[d]  = $urandom_range(0, 9) < 7;
                t_stall[d] = $urandom_range(0, 9) < 2;
                t_flush[d] = $urandom_range(0, 19) == 0;
            end
            cyc();
        end
        idle_all();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
